// File: rtl/cordic_iter.sv
// ---------------------------------------------------------------------------
// cordic_iter -- iterative CORDIC engine, one micro-rotation per clock.
//
// The iteration index and the arctangent constant come from outside: an
// external counter supplies count_in and an external ROM supplies
// atan_in = atan(2^-count_in) in the same angle format as z. This block only
// steers that counter (cnt_start / cnt_enable) and trusts whatever index it
// reports; it keeps no iteration count of its own.
//
// Handshake: start is a request sampled only in IDLE. An accepted start
// latches the operands and mode; busy stays high from the next cycle until
// the cycle after done. done is a single-cycle pulse, and the results on
// x_out/y_out/z_out are valid from that cycle and hold until the next done.
// A start seen while busy is dropped, not queued.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   start       : operation request (IDLE only)
//   mode        : 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
//   x_in/y_in/z_in : signed operands, latched with start
//   count_in    : current iteration index from the external counter
//   atan_in     : atan(2^-count_in) from the external ROM
//   cnt_start   : counter restart request (holds the counter at 0)
//   cnt_enable  : counter enable
//   busy        : high in ITER and DONE
//   done        : one-cycle completion pulse
//   x_out/y_out/z_out : registered results
//   dbg_state_o : current FSM state, for observation only
// ---------------------------------------------------------------------------
module cordic_iter #(
    parameter int W        = 16,
    parameter int N_ITER   = 16,
    parameter int CNT_BITS = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] z_in,
    input  logic [CNT_BITS-1:0] count_in,
    input  logic signed [W-1:0] atan_in,
    output logic                cnt_start,
    output logic                cnt_enable,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] z_out,
    output logic [1:0]          dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(N_ITER - 1);

    logic [1:0]          state_q, state_d;
    logic signed [W-1:0] xr_q, xr_d;
    logic signed [W-1:0] yr_q, yr_d;
    logic signed [W-1:0] zr_q, zr_d;
    logic                mr_q, mr_d;
    logic signed [W-1:0] xo_q, xo_d;
    logic signed [W-1:0] yo_q, yo_d;
    logic signed [W-1:0] zo_q, zo_d;

    // Arithmetic right shift. Shifting by W or more leaves only sign bits,
    // so the result is 0 or -1; this is spelled out rather than left to the
    // semantics of an oversized shift amount.
    function automatic logic signed [W-1:0] ashr(input logic signed [W-1:0] v,
                                                 input logic [CNT_BITS-1:0] sh);
        logic signed [W-1:0] r;
        if (int'(sh) >= W) begin
            r = {W{v[W-1]}};
        end else begin
            r = v >>> sh;
        end
        return r;
    endfunction

    // One micro-rotation from the current working registers.
    logic                dir_pos;
    logic signed [W-1:0] y_shifted;
    logic signed [W-1:0] x_shifted;
    logic signed [W-1:0] x_rot, y_rot, z_rot;
    logic                last_iter;

    always_comb begin
        // d = +1 when z is non-negative in rotation mode, or when y is
        // negative in vectoring mode; d = -1 otherwise.
        dir_pos   = mr_q ? yr_q[W-1] : ~zr_q[W-1];
        y_shifted = ashr(yr_q, count_in);
        x_shifted = ashr(xr_q, count_in);
        // Plain W-bit wrap-around arithmetic: no saturation, no gain fix-up.
        if (dir_pos) begin
            x_rot = xr_q - y_shifted;
            y_rot = yr_q + x_shifted;
            z_rot = zr_q - atan_in;
        end else begin
            x_rot = xr_q + y_shifted;
            y_rot = yr_q - x_shifted;
            z_rot = zr_q + atan_in;
        end
        last_iter = (count_in == LAST_IDX);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        mr_d    = mr_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xr_d    = x_in;
                    yr_d    = y_in;
                    zr_d    = z_in;
                    mr_d    = mode;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                xr_d = x_rot;
                yr_d = y_rot;
                zr_d = z_rot;
                if (last_iter) begin
                    // Results are captured on the same edge that enters
                    // DONE, so they are valid while done is high.
                    xo_d    = x_rot;
                    yo_d    = y_rot;
                    zo_d    = z_rot;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            mr_q    <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            mr_q    <= mr_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    // The counter is held at 0 everywhere except ITER, so count_in reads 0
    // in the first ITER cycle. Reset overrides the state so the counter is
    // also restarted when reset lands in the middle of ITER.
    assign cnt_start   = reset || (state_q != S_ITER);
    assign cnt_enable  = 1'b1;
    assign busy        = (state_q == S_ITER) || (state_q == S_DONE);
    assign done        = (state_q == S_DONE);
    assign x_out       = xo_q;
    assign y_out       = yo_q;
    assign z_out       = zo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cordic_iter.sv
// ---------------------------------------------------------------------------
// tb_cordic_iter -- directed bench for cordic_iter.
// Three instances: a (N_ITER=16), b (N_ITER=1) and c (N_ITER=20, so the
// index reaches W and the sign-fill shift path is exercised). Each has its
// own model of the external iteration counter; all share the atan ROM model
// whose angle format maps pi to 0x8000 (pi/4 = 0x2000).
// ---------------------------------------------------------------------------
module tb_cordic_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a, start_b, start_c;
    logic        mode;
    logic [15:0] x_in, y_in, z_in;

    logic [5:0]  cnt_a, cnt_b, cnt_c;
    logic [15:0] atan_a, atan_b, atan_c;
    logic        cs_a, ce_a, busy_a, done_a;
    logic        cs_b, ce_b, busy_b, done_b;
    logic        cs_c, ce_c, busy_c, done_c;
    logic [15:0] xo_a, yo_a, zo_a, xo_b, yo_b, zo_b, xo_c, yo_c, zo_c;
    logic [1:0]  st_a, st_b, st_c;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // atan(2^-i) scaled so that pi = 32768.
    function automatic logic [15:0] atan_rom(input logic [5:0] i);
        logic [15:0] v;
        case (i)
            6'd0:    v = 16'd8192;
            6'd1:    v = 16'd4836;
            6'd2:    v = 16'd2555;
            6'd3:    v = 16'd1297;
            6'd4:    v = 16'd651;
            6'd5:    v = 16'd326;
            6'd6:    v = 16'd163;
            6'd7:    v = 16'd81;
            6'd8:    v = 16'd41;
            6'd9:    v = 16'd20;
            6'd10:   v = 16'd10;
            6'd11:   v = 16'd5;
            6'd12:   v = 16'd3;
            6'd13:   v = 16'd1;
            6'd14:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // External iteration counters: restart wins over enable.
    always @(posedge clock) begin
        if (cs_a) cnt_a <= 6'd0; else if (ce_a) cnt_a <= cnt_a + 6'd1;
        if (cs_b) cnt_b <= 6'd0; else if (ce_b) cnt_b <= cnt_b + 6'd1;
        if (cs_c) cnt_c <= 6'd0; else if (ce_c) cnt_c <= cnt_c + 6'd1;
    end
    assign atan_a = atan_rom(cnt_a);
    assign atan_b = atan_rom(cnt_b);
    assign atan_c = atan_rom(cnt_c);

    cordic_iter #(.W(16), .N_ITER(16), .CNT_BITS(6)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .count_in(cnt_a), .atan_in(atan_a),
        .cnt_start(cs_a), .cnt_enable(ce_a), .busy(busy_a), .done(done_a),
        .x_out(xo_a), .y_out(yo_a), .z_out(zo_a), .dbg_state_o(st_a)
    );

    cordic_iter #(.W(16), .N_ITER(1), .CNT_BITS(6)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .count_in(cnt_b), .atan_in(atan_b),
        .cnt_start(cs_b), .cnt_enable(ce_b), .busy(busy_b), .done(done_b),
        .x_out(xo_b), .y_out(yo_b), .z_out(zo_b), .dbg_state_o(st_b)
    );

    cordic_iter #(.W(16), .N_ITER(20), .CNT_BITS(6)) dut_c (
        .clock(clock), .reset(reset), .start(start_c), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .count_in(cnt_c), .atan_in(atan_c),
        .cnt_start(cs_c), .cnt_enable(ce_c), .busy(busy_c), .done(done_c),
        .x_out(xo_c), .y_out(yo_c), .z_out(zo_c), .dbg_state_o(st_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [15:0] obs, input int exp, input int tol);
        int diff;
        diff = int'($signed(obs)) - exp;
        checks++;
        assert ((diff >= -tol) && (diff <= tol)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, $signed(obs), exp, tol);
        end
    endtask

    function automatic logic sel_done(input int sel);
        logic d;
        case (sel)
            0:       d = done_a;
            1:       d = done_b;
            default: d = done_c;
        endcase
        return d;
    endfunction

    // Issue one start on the chosen instance and wait (bounded) for done.
    // cyc = cycle number in which done was seen, cycle 1 being the one after
    // the accepting edge; 60 means it never came.
    task automatic run_op(input int sel, input logic m, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] z, output int cyc);
        @(negedge clock);
        mode = m; x_in = x; y_in = y; z_in = z;
        start_a = (sel == 0); start_b = (sel == 1); start_c = (sel == 2);
        @(negedge clock);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cyc = 1;
        while (!sel_done(sel) && cyc < 60) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [47:0] held;

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode = 1'b0; x_in = 16'h0; y_in = 16'h0; z_in = 16'h0;

        // ---- reset ----
        repeat (3) @(negedge clock);
        check("rst_cnt_start", {31'b0, cs_a}, 32'd1);
        check("rst_cnt_enable", {31'b0, ce_a}, 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("idle_outputs", {xo_a, yo_a}, 32'h0);
            check("idle_zout", {16'b0, zo_a}, 32'h0);
            check("idle_flags", {28'b0, busy_a, done_a, cs_a, ce_a}, 32'b0011);
        end

        // ---- timing + vectoring, x=y=0x2000 ----
        mode = 1'b1; x_in = 16'h2000; y_in = 16'h2000; z_in = 16'h0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("iter_busy_done", {30'b0, busy_a, done_a}, 32'b10);
            check("iter_count", {26'b0, cnt_a}, k);
            check("iter_cnt_start", {31'b0, cs_a}, 32'd0);
            @(negedge clock);
        end
        check("done_cycle17", {30'b0, busy_a, done_a}, 32'b11);
        check_near("vec_x", xo_a, 32'h4A84, 4);
        check_near("vec_y", yo_a, 0, 4);
        check_near("vec_z", zo_a, 8192, 4);
        @(negedge clock);
        check("after_done", {30'b0, busy_a, done_a}, 32'b00);
        check("after_done_state", {30'b0, st_a}, 32'd0);

        // ---- rotation, x=0x2000 ----
        run_op(0, 1'b0, 16'h2000, 16'h0000, 16'h0000, cyc);
        check("rot_latency", cyc, 32'd17);
        check_near("rot_x", xo_a, 32'h34B2, 4);
        check_near("rot_y", yo_a, 0, 4);
        check_near("rot_z", zo_a, 0, 2);

        // ---- start pulses at cycles 3 and 8 are ignored ----
        @(negedge clock);
        mode = 1'b1; x_in = 16'h2000; y_in = 16'h2000; z_in = 16'h0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 25; c++) begin
            if (done_a) ndone++;
            start_a = (c == 3) || (c == 8);
            if (start_a) begin
                x_in = 16'h1000; y_in = 16'h0123; z_in = 16'h0456; mode = 1'b0;
            end
            @(negedge clock);
        end
        start_a = 1'b0;
        check("ignore_start_ndone", ndone, 32'd1);
        check("ignore_start_result", {xo_a, yo_a}, {16'h4A88, 16'hFFFF});
        check("ignore_start_z", {16'b0, zo_a}, 32'h2000);

        // ---- outputs hold while idle ----
        held = {xo_a, yo_a, zo_a};
        x_in = 16'h7777; y_in = 16'h1111; z_in = 16'h2222;
        repeat (6) @(negedge clock);
        check("hold_outputs", held[47:16], {xo_a, yo_a});
        check("hold_zout", {16'b0, held[15:0]}, {16'b0, zo_a});

        // ---- reset at cycle 5 of ITER ----
        mode = 1'b0; x_in = 16'h2000; y_in = 16'h0; z_in = 16'h0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_reset_busy", {31'b0, busy_a}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_cnt_start", {31'b0, cs_a}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        check("midreset_outputs", {xo_a, yo_a}, 32'h0);
        check("midreset_zout", {16'b0, zo_a}, 32'h0);
        check("midreset_flags", {28'b0, busy_a, done_a, st_a}, 32'h0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_a) ndone++;
            @(negedge clock);
        end
        check("midreset_no_done", ndone, 32'd0);

        // ---- first start after reset behaves normally ----
        run_op(0, 1'b0, 16'h2000, 16'h0000, 16'h0000, cyc);
        check("post_reset_latency", cyc, 32'd17);
        check("post_reset_result", {xo_a, yo_a}, {16'd13492, 16'd1});
        check("post_reset_z", {16'b0, zo_a}, 32'h0);

        // ---- N_ITER=1 ----
        run_op(1, 1'b0, 16'h2000, 16'h0000, 16'h0000, cyc);
        check("niter1_latency", cyc, 32'd2);
        check("niter1_xy", {xo_b, yo_b}, {16'h2000, 16'h2000});
        check("niter1_z", {16'b0, zo_b}, 32'h0000E000);

        // ---- index beyond W: x=-1 rotation over 20 iterations ----
        run_op(2, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, cyc);
        check("niter20_latency", cyc, 32'd21);
        check("signfill_xy", {xo_c, yo_c}, {16'hFFFF, 16'hFFFE});
        check("signfill_z", {16'b0, zo_c}, 32'h0);
        @(negedge clock);
        check("niter20_idle", {30'b0, busy_c, done_c}, 32'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 Parameter W, default 16: signed width of the x, y and z datapath.
REQ-002 Parameter N_ITER, default 16, legal range 1..63: number of CORDIC micro-rotations per operation.
REQ-003 Parameter CNT_BITS, default 6: width of the iteration-counter bus.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  operation request; sampled only in IDLE.
REQ-007 mode  input  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); latched with start.
REQ-008 x_in, y_in, z_in  input  W each  signed operands; latched with start.
REQ-009 count_in  input  CNT_BITS  current iteration index from the iteration counter.
REQ-010 atan_in  input  W  arctangent of 2^-count_in from the arctangent ROM, in the same angle format as z.
REQ-011 cnt_start  output  1  counter restart request.
REQ-012 cnt_enable  output  1  counter enable.
REQ-013 busy  output  1  high while in ITER or DONE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 x_out, y_out, z_out  output  W each  signed results; registered.

Function
REQ-016 FSM states SHALL be IDLE, ITER and DONE, with reset state IDLE.
REQ-017 In IDLE, the block SHALL drive cnt_enable=1 and cnt_start=1, holding the counter at 0 every cycle.
REQ-018 IDLE with start=1 SHALL latch x_in, y_in, z_in and mode into working registers xr, yr, zr and mr, and go to ITER next cycle.
REQ-019 In ITER, the block SHALL drive cnt_enable=1 and cnt_start=0, so count_in reads 0 in the first ITER cycle and increments by 1 per cycle.
REQ-020 In each ITER cycle, with i=count_in: direction d=+1 if (mr=0 and zr>=0) or (mr=1 and yr<0), otherwise d=-1.
REQ-021 In each ITER cycle, the update SHALL be: xr<=xr-d*(yr>>>i), yr<=yr+d*(xr>>>i), zr<=zr-d*atan_in, all computed from pre-update values.
REQ-022 >>> SHALL be an arithmetic shift; for i>=W, the result SHALL be all sign bits (0 or -1).
REQ-023 All additions SHALL be W-bit two's-complement with wrap-around; no saturation and no gain compensation.
REQ-024 When count_in==N_ITER-1 in ITER, that update SHALL be performed and the FSM SHALL go to DONE.
REQ-025 On entering DONE, x_out, y_out and z_out SHALL load the final xr, yr and zr.
REQ-026 In DONE, the block SHALL assert done=1 for exactly one cycle, drive cnt_enable=1 and cnt_start=1, and return to IDLE.
REQ-027 Latency: with start accepted at edge 0, done SHALL be high during cycle N_ITER+1, and the next start SHALL be accepted the cycle after done.
REQ-028 start while busy=1 SHALL be ignored: no relatch and no effect on the current operation.
REQ-029 x_out, y_out and z_out SHALL hold their value until the next DONE.
REQ-030 The block SHALL trust count_in; it SHALL NOT maintain an internal iteration count.

Reset
REQ-031 reset=1 SHALL force IDLE, done=0, busy=0, xr/yr/zr=0 and x_out/y_out/z_out=0 on the next edge, including mid-ITER.
REQ-032 During reset, the block SHALL drive cnt_start=1 and cnt_enable=1.
REQ-033 After reset, the first start SHALL behave exactly as REQ-018.

Verification
REQ-034 Reset release: all outputs 0, busy=0, cnt_start=1, cnt_enable=1 -> hold for 5 idle cycles with no change.
REQ-035 Timing: start pulse with N_ITER=16 -> busy rises the next cycle; count_in sequence 0..15; done high exactly in cycle 17 for 1 cycle.
REQ-036 Vectoring: x_in=0x2000, y_in=0x2000, z_in=0, using the bench ROM model -> y_out within ±4 LSB of 0, x_out within ±4 LSB of 0x4A84, z_out = pi/4 code within ±4 LSB.
REQ-037 Rotation: x_in=0x2000, y_in=0, z_in=0 -> x_out within ±4 LSB of 0x34B2, y_out within ±4 LSB of 0, z_out within ±2 LSB of 0.
REQ-038 start pulses at cycles 3 and 8 during an active operation -> a single done and results unchanged; reset at cycle 5 of ITER -> outputs 0 and IDLE next cycle, with no done pulse.
REQ-039 Edge case: N_ITER=1 -> done in cycle 2; shift edge x_in=-1 (0xFFFF) at i>=W -> yr+=d*(-1) applied as sign fill, matching the bench reference model bit-exactly.
